// File: rtl/hazard_pkg.sv
// hazard_pkg: shared entry layout and forwarding-select constants for hazard_ctrl
package hazard_pkg;
  localparam int AW_MAX = 8;
  localparam int FWD_SEL_W = 3;
  localparam logic [FWD_SEL_W-1:0] FWD_NONE = '0;
  typedef struct packed {
    logic vld;
    logic wr;
    logic ld;
    logic rs_u;
    logic rt_u;
    logic [AW_MAX-1:0] rd;
    logic [AW_MAX-1:0] rs;
    logic [AW_MAX-1:0] rt;
  } entry_t;
endpackage

// File: rtl/hazard_shadow_stage.sv
// hazard_shadow_stage: one shadow pipeline entry register, frozen while hold is high
module hazard_shadow_stage
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  entry_t d,
  output entry_t q
);
  // capture the upstream entry unless the pipeline is frozen
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (!hold) q <= d;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/bubble/flush generation, EX forwarding selects and stall counting
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW        = 3,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 1,
  parameter int RF_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dec_valid,
  input  logic [AW-1:0]        dec_rs,
  input  logic [AW-1:0]        dec_rt,
  input  logic                 dec_rs_used,
  input  logic                 dec_rt_used,
  input  logic [AW-1:0]        dec_rd,
  input  logic                 dec_wr_en,
  input  logic                 dec_is_load,
  input  logic                 br_taken,
  input  logic                 hold,
  output logic                 stall,
  output logic                 bubble,
  output logic                 flush,
  output logic [FWD_SEL_W-1:0] fwd_rs_sel,
  output logic [FWD_SEL_W-1:0] fwd_rt_sel,
  output logic [CNT_W-1:0]     stall_cnt
);
  entry_t e [DEPTH];
  entry_t d [DEPTH];
  logic [AW_MAX-1:0] rs_x, rt_x;
  logic haz_rs, haz_rt, haz;

  function automatic logic match(input entry_t x, input logic [AW_MAX-1:0] s);
    return x.vld & x.wr & (x.rd == s);
  endfunction

  assign rs_x = AW_MAX'(dec_rs);
  assign rt_x = AW_MAX'(dec_rt);

  // with forwarding only a load right ahead blocks; otherwise any unretired writer blocks
  always_comb begin
    haz_rs = 1'b0;
    haz_rt = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if (FWD_EN != 0 ? (k == 0 && e[k].ld) : (k < DEPTH - RF_BYPASS)) begin
        haz_rs = haz_rs | match(e[k], rs_x);
        haz_rt = haz_rt | match(e[k], rt_x);
      end
  end

  assign haz    = dec_valid & ((dec_rs_used & haz_rs) | (dec_rt_used & haz_rt));
  assign flush  = br_taken;
  assign stall  = haz & ~br_taken;
  assign bubble = stall | br_taken;

  // build the next ID/EX entry and the shift chain inputs
  always_comb begin
    d[0] = '0;
    if (dec_valid && !bubble) begin
      d[0].vld  = 1'b1;
      d[0].wr   = dec_wr_en;
      d[0].ld   = dec_is_load;
      d[0].rs_u = dec_rs_used;
      d[0].rt_u = dec_rt_used;
      d[0].rd   = AW_MAX'(dec_rd);
      d[0].rs   = rs_x;
      d[0].rt   = rt_x;
    end
    for (int k = 1; k < DEPTH; k++) d[k] = e[k-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    hazard_shadow_stage u_stage (
      .clk  (clk),
      .rst  (rst),
      .hold (hold),
      .d    (d[i]),
      .q    (e[i])
    );
  end

  // scan oldest to youngest so the youngest matching producer is the one left selected
  always_comb begin
    fwd_rs_sel = FWD_NONE;
    fwd_rt_sel = FWD_NONE;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (FWD_EN != 0 && e[0].rs_u && match(e[k], e[0].rs)) fwd_rs_sel = FWD_SEL_W'(k);
      if (FWD_EN != 0 && e[0].rt_u && match(e[k], e[0].rt)) fwd_rt_sel = FWD_SEL_W'(k);
    end
  end

  // saturating count of stalled cycles, frozen with the pipeline
  always_ff @(posedge clk or posedge rst)
    if (rst) stall_cnt <= '0;
    else if (stall && !hold && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of forwarding and interlock hazard controllers
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic dec_valid, dec_rs_used, dec_rt_used, dec_wr_en, dec_is_load, br_taken, hold;
  logic [2:0] dec_rs, dec_rt, dec_rd;
  logic stall_f, bubble_f, flush_f, stall_i, bubble_i, flush_i;
  logic [2:0] rs_sel_f, rt_sel_f, rs_sel_i, rt_sel_i;
  logic [15:0] cnt_f;
  logic [1:0] cnt_i;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.AW(3), .DEPTH(3), .FWD_EN(1), .RF_BYPASS(1), .CNT_W(16)) dut_f (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_rd(dec_rd),
    .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load), .br_taken(br_taken), .hold(hold),
    .stall(stall_f), .bubble(bubble_f), .flush(flush_f),
    .fwd_rs_sel(rs_sel_f), .fwd_rt_sel(rt_sel_f), .stall_cnt(cnt_f)
  );

  hazard_ctrl #(.AW(3), .DEPTH(3), .FWD_EN(0), .RF_BYPASS(1), .CNT_W(2)) dut_i (
    .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_rd(dec_rd),
    .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load), .br_taken(br_taken), .hold(hold),
    .stall(stall_i), .bubble(bubble_i), .flush(flush_i),
    .fwd_rs_sel(rs_sel_i), .fwd_rt_sel(rt_sel_i), .stall_cnt(cnt_i)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic dec(input logic v, input logic [2:0] rs, input logic [2:0] rt,
                     input logic rsu, input logic rtu, input logic [2:0] rd,
                     input logic wr, input logic ld);
    dec_valid = v; dec_rs = rs; dec_rt = rt; dec_rs_used = rsu; dec_rt_used = rtu;
    dec_rd = rd; dec_wr_en = wr; dec_is_load = ld;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; br_taken = 1'b0; hold = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("rst_stall", 16'(stall_f), 0);
    chk("rst_bubble", 16'(bubble_f), 0);
    chk("rst_flush", 16'(flush_f), 0);
    chk("rst_rs_sel", 16'(rs_sel_f), 0);
    chk("rst_rt_sel", 16'(rt_sel_f), 0);
    chk("rst_cnt_f", cnt_f, 0);
    chk("rst_cnt_i", 16'(cnt_i), 0);
    rst = 1'b0;
    tick;
    // interlock: write r4, then read r4 -> two stall cycles
    dec(1, 0, 0, 0, 0, 4, 1, 0); #1;
    chk("il_w_nostall", 16'(stall_i), 0);
    tick;
    dec(1, 4, 0, 1, 0, 5, 1, 0); #1;
    chk("il_stall1", 16'(stall_i), 1);
    chk("il_bubble1", 16'(bubble_i), 1);
    tick;
    chk("il_stall2", 16'(stall_i), 1);
    chk("il_cnt1", 16'(cnt_i), 1);
    tick;
    chk("il_stall_done", 16'(stall_i), 0);
    chk("il_cnt2", 16'(cnt_i), 2);
    tick;
    // second dependent pair pushes the 2-bit counter into saturation
    dec(1, 5, 5, 1, 1, 6, 1, 0); #1;
    chk("sat_stall1", 16'(stall_i), 1);
    tick;
    chk("sat_cnt3", 16'(cnt_i), 3);
    chk("sat_stall2", 16'(stall_i), 1);
    tick;
    chk("sat_hold3", 16'(cnt_i), 3);
    chk("sat_stall_done", 16'(stall_i), 0);
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1; tick; rst = 1'b0; tick;
    // forwarding: ld r2 then add r3,r2,r4 -> one bubble
    dec(1, 1, 0, 1, 0, 2, 1, 1); #1;
    chk("lu_ld_nostall", 16'(stall_f), 0);
    tick;
    dec(1, 2, 4, 1, 1, 3, 1, 0); #1;
    chk("lu_stall", 16'(stall_f), 1);
    chk("lu_bubble", 16'(bubble_f), 1);
    chk("lu_flush", 16'(flush_f), 0);
    tick;
    chk("lu_stall_once", 16'(stall_f), 0);
    chk("lu_bubble_once", 16'(bubble_f), 0);
    chk("lu_cnt", cnt_f, 1);
    tick;
    dec(0, 0, 0, 0, 0, 0, 0, 0); #1;
    // the bubble puts the load two entries ahead of the add
    chk("lu_fwd_rs", 16'(rs_sel_f), 2);
    chk("lu_fwd_rt", 16'(rt_sel_f), 0);
    tick;
    // add r1 then sub r5,r1,r1 -> no stall, both operands from entry 1
    dec(1, 2, 3, 1, 1, 1, 1, 0); #1;
    chk("alu_add_nostall", 16'(stall_f), 0);
    tick;
    dec(1, 1, 1, 1, 1, 5, 1, 0); #1;
    chk("alu_sub_nostall", 16'(stall_f), 0);
    chk("alu_sub_nobubble", 16'(bubble_f), 0);
    tick;
    dec(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("alu_fwd_rs", 16'(rs_sel_f), 1);
    chk("alu_fwd_rt", 16'(rt_sel_f), 1);
    // branch taken together with a load-use hazard
    dec(1, 0, 0, 0, 0, 2, 1, 1);
    tick;
    dec(1, 2, 2, 1, 1, 6, 1, 0); br_taken = 1'b1; #1;
    chk("br_flush", 16'(flush_f), 1);
    chk("br_bubble", 16'(bubble_f), 1);
    chk("br_stall", 16'(stall_f), 0);
    tick;
    br_taken = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("br_e0_invalid", 16'(rs_sel_f), 0);
    chk("br_cnt", cnt_f, 1);
    // hold for 5 cycles during a load-use stall
    dec(1, 0, 0, 0, 0, 3, 1, 1);
    tick;
    dec(1, 3, 0, 1, 0, 7, 1, 0); #1;
    chk("hold_pre_stall", 16'(stall_f), 1);
    hold = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick;
      chk("hold_stall", 16'(stall_f), 1);
      chk("hold_cnt", cnt_f, 1);
    end
    hold = 1'b0;
    tick;
    chk("hold_released", 16'(stall_f), 0);
    chk("hold_cnt_after", cnt_f, 2);
    tick;
    dec(0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("hold_fwd_rs", 16'(rs_sel_f), 2);
    // asynchronous reset in the middle of a stall
    dec(1, 0, 0, 0, 0, 4, 1, 1);
    tick;
    dec(1, 4, 0, 1, 0, 1, 1, 0); #1;
    chk("ar_pre_stall", 16'(stall_f), 1);
    chk("ar_pre_cnt", cnt_f, 2);
    #1 rst = 1'b1;
    #1;
    chk("ar_stall", 16'(stall_f), 0);
    chk("ar_bubble", 16'(bubble_f), 0);
    chk("ar_cnt", cnt_f, 0);
    tick;
    rst = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
